// File: rtl/mem_line_adapter.sv
// Splits one cache-line request into BEATS single-word bus transfers and reassembles
// read beats into a line; completion is a one-cycle registered mem_ready pulse.
module mem_line_adapter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_wr,
  input  logic                  mem_rw,
  input  logic                  mem_valid_out,
  output logic [BLOCK_SIZE-1:0] mem_rd,
  output logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  output logic                  bus_req,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  busy
);

  localparam int BEATS     = BLOCK_SIZE / DATA_WIDTH;
  localparam int BEAT_BITS = $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_state_next;
  logic [BEAT_BITS-1:0]             r_beat;
  logic [ADDR_WIDTH-BEAT_BITS-1:0]  r_line_addr;
  logic                             r_rw;
  logic [BLOCK_SIZE-1:0]            r_wline;
  logic [BLOCK_SIZE-1:0]            r_buf;
  logic [BLOCK_SIZE-1:0]            r_mem_rd;
  logic                             r_ready;
  logic [BLOCK_SIZE-1:0]            w_buf_next;
  logic                             w_xfer;
  logic                             w_beat_done;
  logic                             w_last_beat;

  // Bus handshake: a beat is presented while bus_req is high and completes in the cycle
  // bus_ack is sampled high with it; bus_ack with bus_req low is ignored.
  assign w_xfer      = (r_state == S_XFER);
  assign w_beat_done = w_xfer && bus_ack;
  assign w_last_beat = (r_beat == BEAT_BITS'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (mem_valid_out) w_state_next = S_XFER;
      S_XFER:  if (bus_ack && w_last_beat) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_buf_next = r_buf;
    if (w_beat_done && !r_rw)
      w_buf_next[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] = bus_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= '0;
      r_line_addr <= '0;
      r_rw        <= 1'b0;
      r_wline     <= '0;
      r_buf       <= '0;
      r_mem_rd    <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= w_beat_done && w_last_beat;
      if (r_state == S_IDLE && mem_valid_out) begin
        r_line_addr <= mem_addr[ADDR_WIDTH-1:BEAT_BITS];
        r_rw        <= mem_rw;
        r_wline     <= mem_wr;
        r_beat      <= '0;
      end
      if (w_beat_done) begin
        r_buf  <= w_buf_next;
        // Beat index wraps inside the line; it never touches the line address.
        r_beat <= r_beat + BEAT_BITS'(1);
        if (w_last_beat && !r_rw) r_mem_rd <= w_buf_next;
      end
    end
  end

  assign bus_req   = w_xfer;
  assign bus_we    = w_xfer && r_rw;
  assign bus_addr  = w_xfer ? {r_line_addr, r_beat} : '0;
  assign bus_wdata = w_xfer ? r_wline[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy      = (r_state != S_IDLE);
  assign mem_rd    = r_mem_rd;
  assign mem_ready = r_ready;

endmodule

// File: tb/tb_mem_line_adapter.sv
// Bench for mem_line_adapter: bus responder with programmable wait states, beat and
// completion scoreboards, directed line transfers including reset mid-transfer.
module tb_mem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [27:0]  mem_addr;
  logic [255:0] mem_wr;
  logic         mem_rw;
  logic         mem_valid_out;
  logic [255:0] mem_rd;
  logic         mem_ready;
  logic [27:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_we;
  logic         bus_req;
  logic [31:0]  bus_rdata = 32'h0;
  logic         bus_ack = 1'b0;
  logic         busy;

  mem_line_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_wr        (mem_wr),
    .mem_rw        (mem_rw),
    .mem_valid_out (mem_valid_out),
    .mem_rd        (mem_rd),
    .mem_ready     (mem_ready),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_we        (bus_we),
    .bus_req       (bus_req),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack),
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [60:0]  exp_beat_q[$];   // {we, addr, wdata}
  int           exp_cyc_q[$];
  logic [255:0] exp_rd_q[$];
  logic [255:0] model_rd = '0;
  int           wait_cfg = 0;
  int           wcnt = 0;
  logic         force_ack = 1'b0;
  logic [31:0]  rd_base = 32'h0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bus responder: acks after wait_cfg idle cycles; checks every presented beat.
  always @(negedge clk) begin
    if (rst || !bus_req) begin
      bus_ack   = force_ack;
      bus_rdata = 32'hDEAD_BEEF;
      wcnt      = 0;
    end else begin
      if (exp_beat_q.size() == 0)
        check_eq("unexpected_beat", 256'(exp_beat_q.size()), 256'(1));
      else
        check_eq("beat", 256'({bus_we, bus_addr, bus_wdata}), 256'(exp_beat_q[0]));
      if (wcnt < wait_cfg) begin
        bus_ack = 1'b0;
        wcnt++;
      end else begin
        bus_ack   = 1'b1;
        bus_rdata = rd_base + 32'(bus_addr[2:0]);
        wcnt      = 0;
        if (exp_beat_q.size() != 0) void'(exp_beat_q.pop_front());
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (mem_ready) begin
      if (exp_cyc_q.size() == 0) begin
        check_eq("spurious_ready", 256'(exp_cyc_q.size()), 256'(1));
      end else begin
        check_eq("ready_cycle", 256'(cyc), 256'(exp_cyc_q.pop_front()));
        check_eq("mem_rd", mem_rd, exp_rd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_line(input logic [27:0] addr, input logic rw, input logic [255:0] wl,
                          input int waits, input logic keep_valid);
    int           t;
    logic [255:0] rl;
    logic         seen;
    seen = 1'b0;
    t = busy ? cyc + 1 : cyc;
    wait_cfg      = waits;
    mem_addr      = addr;
    mem_rw        = rw;
    mem_wr        = wl;
    mem_valid_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_beat_q.push_back({rw, addr[27:3], 3'(k), wl[32*k +: 32]});
      rl[32*k +: 32] = rd_base + 32'(k);
    end
    if (!rw) model_rd = rl;
    exp_cyc_q.push_back(t + 9 + 8 * waits);
    exp_rd_q.push_back(model_rd);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = mem_ready;
    end
    check_eq("ready_seen", 256'(seen), 256'(1));
    if (!keep_valid) mem_valid_out = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"},   256'(bus_req), 256'(0));
    check_eq({tag, "_busy"},  256'(busy), 256'(0));
    check_eq({tag, "_ready"}, 256'(mem_ready), 256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] wl;
    logic         found;

    rst           = 1'b1;
    mem_valid_out = 1'b1;
    mem_rw        = 1'b0;
    mem_addr      = 28'h000123D;
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
    mem_wr = wl;

    // Reset held two cycles with a pending request.
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("rst");
      check_eq("rst_we",    256'(bus_we), 256'(0));
      check_eq("rst_addr",  256'(bus_addr), 256'(0));
      check_eq("rst_wdata", 256'(bus_wdata), 256'(0));
      check_eq("rst_mem_rd", mem_rd, 256'(0));
    end
    rst           = 1'b0;
    mem_valid_out = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);

    // Zero-wait read.
    rd_base = 32'h0000_00A0;
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
    run_line(28'h000123D, 1'b0, wl, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Write with two wait cycles per beat.
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = 32'h1111_1111 * 32'(k);
    run_line(28'h0004560, 1'b1, wl, 2, 1'b0);
    repeat (2) @(negedge clk);

    // Write then fill back to back, valid held high; fill at top of address space.
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
    run_line(28'h0BEEF07, 1'b1, wl, $urandom_range(0, 1), 1'b1);
    rd_base = 32'h5000_0000;
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
    run_line(28'hFFFFFFF, 1'b0, wl, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Stray acks in IDLE and DONE are ignored.
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("idle_ack");
    end
    rd_base = 32'h7700_0000;
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
    run_line(28'h0ABCDE5, 1'b0, wl, 0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("post_ack");
    end
    force_ack = 1'b0;
    @(negedge clk);

    // Reset during beat 4 of a read abandons the line.
    rd_base       = 32'h3300_0000;
    mem_addr      = 28'h0000450;
    mem_rw        = 1'b0;
    mem_valid_out = 1'b1;
    wait_cfg      = 0;
    for (int k = 0; k < 8; k++) exp_beat_q.push_back({1'b0, 25'h000008A, 3'(k), wl[32*k +: 32]});
    mem_wr = wl;
    found  = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = bus_req && (bus_addr[2:0] == 3'd4);
    end
    check_eq("beat4_reached", 256'(found), 256'(1));
    rst           = 1'b1;
    mem_valid_out = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check_eq("abort_mem_rd", mem_rd, 256'(0));
    rst = 1'b0;
    exp_beat_q.delete();
    model_rd = '0;
    repeat (12) begin
      @(negedge clk);
      check_idle_outputs("after_abort");
    end

    check_eq("beats_left",   256'(exp_beat_q.size()), 256'(0));
    check_eq("readies_left", 256'(exp_cyc_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
